// File: rtl/hazard_pkg.sv
// Shared types and helpers for the forwarding/hazard scoreboard.
package hazard_pkg;

  // Tag field is wide enough for any practical register file; narrower tags are zero-extended.
  localparam int SB_RD_W     = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               regwrite;
    logic               is_load;
  } sb_entry_t;

  function automatic int calc_sel_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-source youngest-first match against the tracked scoreboard stages.
module fwd_match
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  localparam int SEL_W     = calc_sel_w(DEPTH)
) (
  input  logic [REG_AW-1:0] src,
  input  logic              used,
  input  sb_entry_t         stages [DEPTH-1],
  output logic              hit,
  output logic [SEL_W-1:0]  sel,
  output logic              load_hazard
);

  logic [SB_RD_W-1:0] src_ext;
  assign src_ext = SB_RD_W'(src);

  // Scan oldest to youngest so the youngest producer is the last to overwrite.
  always_comb begin
    hit         = 1'b0;
    sel         = SEL_W'(FWD_REGFILE);
    load_hazard = 1'b0;
    for (int j = DEPTH - 2; j >= 0; j--) begin
      if (used && stages[j].valid && stages[j].regwrite &&
          (stages[j].rd != '0) && (stages[j].rd == src_ext)) begin
        hit         = 1'b1;
        sel         = SEL_W'(j + 1);
        load_hazard = stages[j].is_load && ((j + 1) < LOAD_STAGE);
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_scoreboard.sv
// Forwarding select and load-use stall unit driven by an in-flight destination scoreboard.
// Optional perf counters (stall_cnt, fwd_cnt) are built when HAZARD_PERF_EN is defined.
module fwd_hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
`ifdef HAZARD_PERF_EN
  parameter int CNT_W      = 16,
`endif
  localparam int SEL_W     = calc_sel_w(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      id_valid,
  input  logic [NUM_SRC*REG_AW-1:0] id_src,
  input  logic [NUM_SRC-1:0]        id_src_used,
  input  logic [REG_AW-1:0]         id_rd,
  input  logic                      id_regwrite,
  input  logic                      id_is_load,
  input  logic                      flush,
  output logic                      stall,
  output logic                      ex_valid,
  output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          fwd_cnt
`endif
);

  // The oldest (WB) stage is never selected, so only stages 0..DEPTH-2 are stored.
  sb_entry_t                sb_p0 [DEPTH-1];
  logic [NUM_SRC*SEL_W-1:0] sel_p0;
  logic [NUM_SRC-1:0]       hit;
  logic [NUM_SRC-1:0]       lhaz;
  logic [SEL_W-1:0]         sel_c [NUM_SRC];
  logic                     accept;

  assign stall  = ~rst & id_valid & ~flush & (|lhaz);
  assign accept = id_valid & ~stall & ~flush;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    fwd_match #(
      .REG_AW     (REG_AW),
      .DEPTH      (DEPTH),
      .LOAD_STAGE (LOAD_STAGE)
    ) u_match (
      .src         (id_src[s*REG_AW +: REG_AW]),
      .used        (id_src_used[s]),
      .stages      (sb_p0),
      .hit         (hit[s]),
      .sel         (sel_c[s]),
      .load_hazard (lhaz[s])
    );
  end

  // ---- ID -> EX boundary: scoreboard shift and registered selects ----
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH - 1; k++) sb_p0[k].valid <= 1'b0;
      sel_p0 <= '0;
    end else begin
      sb_p0[0].valid    <= accept;
      sb_p0[0].rd       <= SB_RD_W'(id_rd);
      sb_p0[0].regwrite <= id_regwrite;
      sb_p0[0].is_load  <= id_is_load;
      for (int k = 1; k < DEPTH - 1; k++) sb_p0[k] <= sb_p0[k-1];
      for (int s = 0; s < NUM_SRC; s++)
        sel_p0[s*SEL_W +: SEL_W] <= (accept && hit[s]) ? sel_c[s] : '0;
    end
  end

  assign ex_valid   = sb_p0[0].valid;
  assign ex_fwd_sel = sel_p0;

`ifdef HAZARD_PERF_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      fwd_cnt   <= '0;
    end else begin
      if (stall)            stall_cnt <= sat_inc(stall_cnt);
      if (accept && |hit)   fwd_cnt   <= sat_inc(fwd_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// Directed check of forwarding selects, load-use stall, flush and reset behaviour.
module tb_fwd_hazard_scoreboard;

`ifdef HAZARD_PERF_EN
  localparam int CNT_W = 2;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [9:0] id_src;
  logic [1:0] id_src_used;
  logic [4:0] id_rd;
  logic       id_regwrite;
  logic       id_is_load;
  logic       flush;
  logic       stall;
  logic       ex_valid;
  logic [3:0] ex_fwd_sel;
`ifdef HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] fwd_cnt;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fwd_hazard_scoreboard #(
`ifdef HAZARD_PERF_EN
    .CNT_W       (CNT_W),
`endif
    .REG_AW      (5),
    .NUM_SRC     (2),
    .DEPTH       (3),
    .LOAD_STAGE  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_src      (id_src),
    .id_src_used (id_src_used),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_is_load  (id_is_load),
    .flush       (flush),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_fwd_sel  (ex_fwd_sel)
`ifdef HAZARD_PERF_EN
    ,
    .stall_cnt   (stall_cnt),
    .fwd_cnt     (fwd_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Present one instruction in ID; settles combinational stall before returning.
  task automatic set_id(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used, input logic [4:0] rd,
                        input logic rw, input logic ld);
    id_valid    = v;
    id_src      = {s1, s0};
    id_src_used = used;
    id_rd       = rd;
    id_regwrite = rw;
    id_is_load  = ld;
    #1;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst   = 1'b1;
    flush = 1'b0;
    nop();
    tick();
    tick();
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("reset_sel", {28'd0, ex_fwd_sel}, 32'd0);
    rst = 1'b0;

    // Back-to-back ALU dependency
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 1'b0);   // add r3
    chk("b2b_prod_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("b2b_prod_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("b2b_prod_sel", {28'd0, ex_fwd_sel}, 32'd0);
    set_id(1'b1, 5'd3, 5'd1, 2'b11, 5'd4, 1'b1, 1'b0);   // sub r4 <- r3,r1
    chk("b2b_cons_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("b2b_cons_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("b2b_cons_sel", {28'd0, ex_fwd_sel}, 32'h1);

    // Idle cycle: bubble in EX
    nop();
    tick();
    chk("bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("bubble_sel", {28'd0, ex_fwd_sel}, 32'd0);

    // One-gap ALU dependency
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 1'b0);   // add r7
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd7, 5'd2, 2'b11, 5'd10, 1'b1, 1'b0);  // consumer of r7
    chk("gap1_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("gap1_sel", {28'd0, ex_fwd_sel}, 32'h2);

    // Three-deep dependency: producer already past tracked stages
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd8, 1'b1, 1'b0);   // add r8
    tick();
    nop();
    tick();
    nop();
    tick();
    set_id(1'b1, 5'd8, 5'd8, 2'b11, 5'd12, 1'b1, 1'b0);
    tick();
    chk("deep3_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("deep3_sel", {28'd0, ex_fwd_sel}, 32'd0);

    // Load-use: one stall cycle, then forward from stage 2
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);   // lw r5
    tick();
    set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);   // add r6 <- r5
    chk("lu_stall_on", {31'd0, stall}, 32'd1);
    tick();
    chk("lu_bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("lu_stall_off", {31'd0, stall}, 32'd0);
    tick();
    chk("lu_cons_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("lu_cons_sel", {28'd0, ex_fwd_sel}, 32'h2);

    // Zero register is never forwarded
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 1'b0);   // writes r0
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b01, 5'd11, 1'b1, 1'b0);
    tick();
    chk("r0_sel", {28'd0, ex_fwd_sel}, 32'd0);

    // Youngest of two writers wins; also exercises slot 1
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd4, 1'b1, 1'b0);
    tick();
    set_id(1'b1, 5'd1, 5'd4, 2'b10, 5'd9, 1'b1, 1'b0);
    tick();
    chk("youngest_sel", {28'd0, ex_fwd_sel}, 32'h4);

    // Unused source does not forward
    set_id(1'b1, 5'd9, 5'd0, 2'b00, 5'd13, 1'b1, 1'b0);
    tick();
    chk("unused_src_sel", {28'd0, ex_fwd_sel}, 32'd0);

    // Flush during a load-use stall; scoreboard keeps the load
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
    chk("fl_stall_on", {31'd0, stall}, 32'd1);
    flush = 1'b1;
    #1;
    chk("fl_stall_dropped", {31'd0, stall}, 32'd0);
    tick();
    chk("fl_bubble_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("fl_bubble_sel", {28'd0, ex_fwd_sel}, 32'd0);
    flush = 1'b0;
    #1;
    chk("fl_after_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("fl_after_sel", {28'd0, ex_fwd_sel}, 32'h2);

    // Reset mid-stall
    set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
    tick();
    set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
    chk("rs_stall_on", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rs_stall_dropped", {31'd0, stall}, 32'd0);
    tick();
    chk("rs_ex_valid", {31'd0, ex_valid}, 32'd0);
    chk("rs_sel", {28'd0, ex_fwd_sel}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rs_after_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("rs_after_ex_valid", {31'd0, ex_valid}, 32'd1);
    chk("rs_after_sel", {28'd0, ex_fwd_sel}, 32'd0);

`ifdef HAZARD_PERF_EN
    // Five stall cycles saturate a 2-bit counter
    rst = 1'b1;
    nop();
    tick();
    rst = 1'b0;
    chk("perf_reset_stall_cnt", {30'd0, stall_cnt}, 32'd0);
    chk("perf_reset_fwd_cnt", {30'd0, fwd_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 1'b1);
      tick();
      set_id(1'b1, 5'd5, 5'd0, 2'b01, 5'd6, 1'b1, 1'b0);
      tick();
      tick();
    end
    nop();
    tick();
    chk("perf_stall_cnt_sat", {30'd0, stall_cnt}, 32'd3);
    chk("perf_fwd_cnt_sat", {30'd0, fwd_cnt}, 32'd3);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
